// File: rtl/avg_pkg.sv
// Shared definitions for the integer block-averaging stream stage.
package avg_pkg;

    // Stream data width of both the sample input and the average output.
    localparam int AXIS_DW = 32;

    // Largest supported log2 of the block length.
    localparam int LOG2_N_MAX = 8;

    // ACC: no average pending; HOLD: an average is waiting for downstream.
    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } avg_state_e;

    // Accumulator width that can hold the sum of 2^log2_n full-scale samples.
    function automatic int acc_width(input int log2_n);
        return AXIS_DW + log2_n;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Output holding register for the averaged stream: one data word plus valid.
// Holds while downstream stalls, drops valid after a transfer, and accepts a
// reload on the same cycle an old value leaves so no bubble is inserted.
module axis_out_reg
    import avg_pkg::*;
(
    input  logic               aclk,
    input  logic               rst,
    input  logic               load,
    input  logic [AXIS_DW-1:0] load_data,
    input  logic               m_axis_tready,
    output logic [AXIS_DW-1:0] m_axis_tdata,
    output logic               m_axis_tvalid
);

    logic [AXIS_DW-1:0] data_q;
    logic [AXIS_DW-1:0] data_d;
    logic               valid_q;
    logic               valid_d;

    // Next-state: a reload wins over a drain so back-to-back averages stay valid.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end else if (valid_q && m_axis_tready) begin
            valid_d = 1'b0;
        end
    end

    // Register the held word; reset clears both data and valid.
    always_ff @(posedge aclk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = valid_q;

endmodule

// File: rtl/int_block_avg_axi.sv
// Block averager: sums 2^LOG2_N signed 32-bit samples and emits the floored
// mean (arithmetic shift) on an AXI-stream style output. Input stalls only
// while a finished average is held unaccepted; a partial block keeps
// accumulating otherwise. LOG2_N must lie in 0..LOG2_N_MAX.
module int_block_avg_axi
    import avg_pkg::*;
#(
    parameter int LOG2_N = 3
) (
    input  logic               aclk,
    input  logic               rst,
    input  logic [AXIS_DW-1:0] s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    output logic [AXIS_DW-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [LOG2_N:0]    blk_count
);

    localparam int N     = 1 << LOG2_N;
    localparam int ACC_W = acc_width(LOG2_N);
    localparam int CNT_W = LOG2_N + 1;

    // Index of the sample that closes a block.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    avg_state_e               state_q;
    avg_state_e               state_d;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_d;

    logic                     in_xfer;
    logic                     out_xfer;
    logic                     blk_done;
    logic signed [ACC_W-1:0]  sample_ext;
    logic signed [ACC_W-1:0]  sum;
    logic [AXIS_DW-1:0]       avg;

    // Sign-extend the incoming sample into accumulator width.
    assign sample_ext[AXIS_DW-1:0] = s_axis_tdata;
    generate
        for (genvar gi = AXIS_DW; gi < ACC_W; gi++) begin : g_sext
            assign sample_ext[gi] = s_axis_tdata[AXIS_DW-1];
        end
    endgenerate

    // Handshake decode. Input only stalls while an average sits in HOLD and
    // downstream is not taking it this cycle.
    assign s_axis_tready = !((state_q == HOLD) && !m_axis_tready);
    assign in_xfer       = s_axis_tvalid && s_axis_tready;
    assign out_xfer      = m_axis_tvalid && m_axis_tready;
    assign blk_done      = in_xfer && (cnt_q == LAST_IDX);

    // Running sum including the sample arriving this cycle; the average is the
    // sum arithmetically shifted right by LOG2_N (floor), taken as 32 bits.
    // The accumulator is wide enough that the sum never overflows.
    assign sum = acc_q + sample_ext;
    assign avg = sum[LOG2_N +: AXIS_DW];

    // Accumulator / counter / FSM next-state.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        state_d = state_q;

        if (blk_done) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (in_xfer) begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ACC: begin
                if (blk_done) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_xfer && !blk_done) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    // Sequential state; reset discards any partial block and pending average.
    always_ff @(posedge aclk) begin
        if (rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= ACC;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign blk_count = cnt_q;

    axis_out_reg u_out_reg (
        .aclk          (aclk),
        .rst           (rst),
        .load          (blk_done),
        .load_data     (avg),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid)
    );

endmodule

// File: tb/tb_int_block_avg_axi.sv
// Bench for the block averager: drives two instances (N=8 and N=1) with the
// same stimulus and compares them every cycle against a sample-list model.
module tb_int_block_avg_axi;

    logic        aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        m_ready;

    logic        s_ready0, s_ready1;
    logic [31:0] m_data0, m_data1;
    logic        m_valid0, m_valid1;
    logic [3:0]  cnt0;
    logic [0:0]  cnt1;

    int errors = 0;
    int checks = 0;

    // Model state per instance: running sum, samples in block, pending output.
    longint      md_acc [2];
    int          md_cnt [2];
    logic        md_v   [2];
    logic [31:0] md_d   [2];
    int          nsz    [2];

    logic [31:0] got_q[$];

    int_block_avg_axi #(.LOG2_N(3)) dut0 (
        .aclk(aclk), .rst(rst),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready0),
        .m_axis_tdata(m_data0), .m_axis_tvalid(m_valid0), .m_axis_tready(m_ready),
        .blk_count(cnt0)
    );

    int_block_avg_axi #(.LOG2_N(0)) dut1 (
        .aclk(aclk), .rst(rst),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready1),
        .m_axis_tdata(m_data1), .m_axis_tvalid(m_valid1), .m_axis_tready(m_ready),
        .blk_count(cnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Floor of sum/n using plain integer division.
    function automatic logic [31:0] floor_avg(input longint s, input int n);
        longint q;
        q = s / n;
        if ((s % n) != 0 && s < 0) q = q - 1;
        return q[31:0];
    endfunction

    task automatic compare();
        chk("m_valid0", {31'b0, m_valid0}, {31'b0, md_v[0]});
        if (md_v[0]) chk("m_data0", m_data0, md_d[0]);
        chk("blk_count0", {28'b0, cnt0}, md_cnt[0]);
        chk("m_valid1", {31'b0, m_valid1}, {31'b0, md_v[1]});
        if (md_v[1]) chk("m_data1", m_data1, md_d[1]);
        chk("blk_count1", {31'b0, cnt1}, md_cnt[1]);
    endtask

    // One clock cycle: check outputs, apply inputs, advance the model.
    task automatic cyc(input logic iv, input logic [31:0] id, input logic irdy, input logic irst);
        logic        sr, ox, ix, done;
        logic [31:0] nd;
        @(negedge aclk);
        compare();
        s_valid = iv; s_data = id; m_ready = irdy; rst = irst;
        #1;
        chk("s_ready0", {31'b0, s_ready0}, {31'b0, !(md_v[0] && !irdy)});
        chk("s_ready1", {31'b0, s_ready1}, {31'b0, !(md_v[1] && !irdy)});
        if (!irst && md_v[0] && irdy) got_q.push_back(m_data0);
        for (int k = 0; k < 2; k++) begin
            if (irst) begin
                md_acc[k] = 0; md_cnt[k] = 0; md_v[k] = 1'b0; md_d[k] = '0;
            end else begin
                sr = !(md_v[k] && !irdy);
                ox = md_v[k] && irdy;
                ix = iv && sr;
                done = 1'b0;
                nd = '0;
                if (ix) begin
                    md_acc[k] += longint'($signed(id));
                    md_cnt[k]++;
                    if (md_cnt[k] == nsz[k]) begin
                        done = 1'b1;
                        nd = floor_avg(md_acc[k], nsz[k]);
                        md_acc[k] = 0;
                        md_cnt[k] = 0;
                    end
                end
                if (done) begin
                    md_v[k] = 1'b1; md_d[k] = nd;
                end else if (ox) begin
                    md_v[k] = 1'b0;
                end
            end
        end
        @(posedge aclk);
    endtask

    task automatic check_got(input string name, input int n, input logic [31:0] e0, input logic [31:0] e1);
        chk({name, "_count"}, got_q.size(), n);
        if (got_q.size() > 0) chk({name, "_out0"}, got_q[0], e0);
        if (n > 1 && got_q.size() > 1) chk({name, "_out1"}, got_q[1], e1);
        $display("case %s: %0d averages observed", name, got_q.size());
        got_q.delete();
    endtask

    initial begin
        int          a[8];
        logic        rv, rr, rs;
        logic [31:0] rd;
        nsz[0] = 8; nsz[1] = 1;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        repeat (2) @(posedge aclk);
        for (int k = 0; k < 2; k++) begin
            md_acc[k] = 0; md_cnt[k] = 0; md_v[k] = 1'b0; md_d[k] = '0;
        end
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b1);
        got_q.delete();

        // Eight samples of 100.
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'd100, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
        check_got("avg100", 1, 32'd100, '0);

        // Negative floor cases.
        a = '{-3, -2, -1, 0, 0, 0, 0, 1};
        for (int i = 0; i < 8; i++) cyc(1'b1, a[i], 1'b1, 1'b0);
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);
        check_got("floor_neg5", 1, 32'hFFFF_FFFF, '0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);
        check_got("all_minus1", 1, 32'hFFFF_FFFF, '0);

        // Full-scale extremes must not wrap.
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'h8000_0000, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);
        check_got("extremes", 2, 32'h7FFF_FFFF, 32'h8000_0000);

        // Backpressure: block completes with ready low, held 5 cycles.
        for (int i = 0; i < 7; i++) cyc(1'b1, 32'd20, 1'b1, 1'b0);
        cyc(1'b1, 32'd20, 1'b0, 1'b0);
        repeat (5) cyc(1'b1, 32'd7, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'd7, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);
        check_got("backpressure", 2, 32'd20, 32'd7);

        // Continuous 0..15 with ready high.
        for (int i = 0; i < 16; i++) cyc(1'b1, i, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);
        check_got("ramp16", 2, 32'd3, 32'd11);

        // Reset mid-block discards the partial sum.
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'd50, 1'b1, 1'b0);
        cyc(1'b1, 32'd50, 1'b1, 1'b1);
        #1;
        chk("cnt_after_rst", {28'b0, cnt0}, 32'd0);
        chk("valid_after_rst", {31'b0, m_valid0}, 32'd0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'd10, 1'b1, 1'b0);
        #1;
        chk("ready_after_blocks", {31'b0, s_ready0}, 32'd1);
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);
        check_got("reset_midblock", 1, 32'd10, '0);

        // N=1 instance passes samples straight through one cycle later.
        cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        #1;
        chk("pass_valid", {31'b0, m_valid1}, 32'd1);
        chk("pass_data", m_data1, 32'hDEAD_BEEF);
        cyc(1'b1, 32'h1234_5678, 1'b1, 1'b0);
        #1;
        chk("pass_b2b_valid", {31'b0, m_valid1}, 32'd1);
        chk("pass_b2b_data", m_data1, 32'h1234_5678);

        // Randomized traffic with random backpressure and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            rv = ($urandom_range(0, 9) < 7);
            rr = ($urandom_range(0, 9) < 6);
            rs = ($urandom_range(0, 299) == 0);
            case ($urandom_range(0, 3))
                0:       rd = 32'h7FFF_FFFF;
                1:       rd = 32'h8000_0000;
                default: rd = $urandom;
            endcase
            cyc(rv, rd, rr, rs);
        end
        repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
        @(negedge aclk);
        compare();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/int_block_avg_axi.md
INT_BLOCK_AVG_AXI -- requirements
Module: int_block_avg_axi

Interface
REQ-001 Parameter LOG2_N, default 3, log2 of samples per averaging block (N = 2^LOG2_N); legal range 0..8.
REQ-002 aclk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 s_axis_tdata  input  32  signed two's-complement integer sample from the float-to-int stage.
REQ-005 s_axis_tvalid  input  1  upstream sample valid.
REQ-006 s_axis_tready  output  1  block accepts a sample this cycle.
REQ-007 m_axis_tdata  output  32  signed block average.
REQ-008 m_axis_tvalid  output  1  average valid.
REQ-009 m_axis_tready  input  1  downstream accepts the average.
REQ-010 blk_count  output  LOG2_N+1  samples accumulated in the current block, 0..N-1.

Function
REQ-011 An input transfer SHALL occur on a cycle where s_axis_tvalid and s_axis_tready are both 1.
REQ-012 An output transfer SHALL occur on a cycle where m_axis_tvalid and m_axis_tready are both 1.
REQ-013 s_axis_tready SHALL equal NOT (m_axis_tvalid AND NOT m_axis_tready) (combinational); input SHALL stall only while an average is held unaccepted.
REQ-014 Accumulator SHALL be signed, 32+LOG2_N bits wide; each input transfer SHALL add the sign-extended sample; no overflow is possible.
REQ-015 On the input transfer that completes a block (blk_count = N-1), the block SHALL register m_axis_tdata = (acc + sample) arithmetically shifted right by LOG2_N, truncated to 32 bits (floor toward minus infinity); it SHALL set m_axis_tvalid = 1 on the next edge and clear acc and blk_count to 0 on that same edge.
REQ-016 Latency: m_axis_tvalid SHALL rise exactly one cycle after the completing input transfer.
REQ-017 m_axis_tdata and m_axis_tvalid SHALL hold stable while m_axis_tvalid = 1 and m_axis_tready = 0.
REQ-018 m_axis_tvalid SHALL clear on the edge after an output transfer unless a new block completes on that same cycle, in which case it SHALL stay 1 with the new value (back-to-back, no bubble).
REQ-019 FSM states:
  ACC: no average pending.
  HOLD: average pending.
  ACC -> HOLD on a completing transfer.
  HOLD -> ACC on an output transfer without a simultaneous completion.
  HOLD -> HOLD on an output transfer with a simultaneous completion, or when no output transfer occurs.
REQ-020 In HOLD with m_axis_tready = 0, input transfers are blocked per REQ-013; accumulation of a partial block SHALL otherwise continue in both states.
REQ-021 With LOG2_N = 0, every accepted sample SHALL pass through unchanged with 1-cycle latency.
REQ-022 blk_count SHALL wrap N-1 -> 0 only on a completing transfer; it SHALL increment by 1 on every other input transfer.

Reset
REQ-023 While rst = 1 at a rising edge, the following SHALL be cleared to 0: acc, blk_count, m_axis_tdata, m_axis_tvalid. State SHALL return to ACC.
REQ-024 Reset mid-block SHALL discard the partial sum; the first input transfer after reset deasserts SHALL start a fresh block.
REQ-025 Reset SHALL override any simultaneous input or output transfer.
REQ-026 s_axis_tready SHALL be 1 in the cycle after reset releases.

Structure
REQ-027 Shared package avg_pkg SHALL hold: the state enum (ACC, HOLD), AXIS_DW = 32, and LOG2_N_MAX = 8.
REQ-028 The output holding register SHALL be a sub-module axis_out_reg: a 32-bit data plus valid register with ready-based hold and same-cycle reload.
REQ-029 No other sub-modules; accumulator and counter SHALL be in the top level.

Verification (LOG2_N = 3 unless stated)
REQ-030 Eight samples of 100, m_axis_tready = 1 -> one output of 100, m_axis_tvalid high for one cycle, 1 cycle after the 8th transfer.
REQ-031 Samples -3,-2,-1,0,0,0,0,1 (sum -5) -> output 0xFFFFFFFF (-1, floor); eight samples of -1 -> -1.
REQ-032 Eight samples of 0x7FFFFFFF -> 0x7FFFFFFF; eight samples of 0x80000000 -> 0x80000000 (no wrap).
REQ-033 Backpressure: block completes with m_axis_tready = 0 held 5 cycles -> m_axis_tdata stable; s_axis_tready = 0 for those cycles; no samples lost; the next block is correct.
REQ-034 Continuous valid, m_axis_tready = 1, 16 samples 0..15 -> outputs 3 then 11 with no stall; also cover the simultaneous output transfer plus completion case.
REQ-035 Five samples of 50, then rst for 1 cycle, then eight samples of 10 -> single output 10; blk_count = 0 after reset.
